// File: rtl/mf8_ifetch.sv
// mf8_ifetch -- instruction fetch stage of the mf8 core.
// Drives the program ROM from the sequencer's next PC and captures ROM words into IR/IR2.
// It also owns PC redirection (Pause/RJmp/Offs_Out) for stalls, skips and taken branches.
// Optional feature macro: MF8_IF_LONG_EN enables 32-bit opcodes (LDS/STS/JMP/CALL)
// together with the WORD2 and SKIP2 states. Without it, every opcode is one word and IR2 reads 0.
module mf8_ifetch #(
    parameter int AW = 12,   // program word-address width, equal to the PC width
    parameter int DW = 16    // instruction word width; the opcode masks assume 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [AW-1:0] NPC,
    output logic [AW-1:0] ROM_Addr,
    input  logic [DW-1:0] ROM_Data,
    input  logic          Stall,
    input  logic          Skip,
    input  logic          Br_Taken,
    input  logic [AW-1:0] Br_Offs,
    output logic          Pause,
    output logic          RJmp,
    output logic [AW-1:0] Offs_Out,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] IR2,
    output logic          IR_Valid
);

`ifdef MF8_IF_LONG_EN
    typedef enum logic [2:0] {
        FILL  = 3'd0,
        RUN   = 3'd1,
        WORD2 = 3'd2,
        SKIP  = 3'd3,
        SKIP2 = 3'd4
    } state_t;

    // LDS/STS and JMP/CALL carry a second operand word
    function automatic logic is_long(input logic [DW-1:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction
`else
    typedef enum logic [2:0] {
        FILL = 3'd0,
        RUN  = 3'd1,
        SKIP = 3'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          valid_q, valid_d;
    logic          pause_c;
    logic          rjmp_c;
    logic [AW-1:0] offs_c;

    // The ROM address is a pure pass-through, live even while in reset
    assign ROM_Addr = NPC;

    // Sequencer controls are forced idle while reset is asserted
    assign Pause    = Reset_n & pause_c;
    assign RJmp     = Reset_n & rjmp_c;
    assign Offs_Out = Reset_n ? offs_c : '0;
    assign IR       = ir_q;
    assign IR_Valid = valid_q;

`ifdef MF8_IF_LONG_EN
    logic [DW-1:0] ir2_q, ir2_d;
    assign IR2 = ir2_q;
`else
    assign IR2 = '0;
`endif

    // State, instruction register and valid flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FILL;
            ir_q    <= '0;
            valid_q <= 1'b0;
`ifdef MF8_IF_LONG_EN
            ir2_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
`ifdef MF8_IF_LONG_EN
            ir2_q   <= ir2_d;
`endif
        end
    end

    // Next-state and redirect logic; priority is Br_Taken, then Skip, then Stall
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        pause_c = 1'b0;
        rjmp_c  = 1'b0;
        offs_c  = '0;
`ifdef MF8_IF_LONG_EN
        ir2_d   = ir2_q;
`endif
        if (Br_Taken) begin
            // PC already points one past the branch, so compensate by one
            rjmp_c  = 1'b1;
            offs_c  = Br_Offs - AW'(1);
            ir_d    = '0;
            valid_d = 1'b0;
            state_d = FILL;
        end else begin
            case (state_q)
                // ROM output belongs to the pre-redirect PC: drop it
                FILL: begin
                    valid_d = 1'b0;
                    state_d = RUN;
                end
                // A short skip resolves in its pulse cycle, so SKIP is never
                // held; it decodes exactly like RUN
                RUN, SKIP: begin
                    if (Skip) begin
                        valid_d = 1'b0;
`ifdef MF8_IF_LONG_EN
                        state_d = is_long(ROM_Data) ? SKIP2 : RUN;
`else
                        state_d = RUN;
`endif
                    end else if (Stall) begin
                        pause_c = 1'b1;
                    end else begin
                        ir_d = ROM_Data;
`ifdef MF8_IF_LONG_EN
                        if (is_long(ROM_Data)) begin
                            valid_d = 1'b0;
                            state_d = WORD2;
                        end else begin
                            valid_d = 1'b1;
                            state_d = RUN;
                        end
`else
                        valid_d = 1'b1;
                        state_d = RUN;
`endif
                    end
                end
`ifdef MF8_IF_LONG_EN
                // Operand word completes the 32-bit instruction; a stall
                // applies only once it has been captured
                WORD2: begin
                    ir2_d   = ROM_Data;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
                // Throw away the operand of a skipped 32-bit instruction
                SKIP2: begin
                    valid_d = 1'b0;
                    state_d = RUN;
                end
`endif
                default: begin
                    valid_d = 1'b0;
                    state_d = FILL;
                end
            endcase
        end
    end

endmodule
